// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer.
// Define PIPE_STAT_EN to add the saturating stall_cnt/bubble_cnt statistics ports.
module pipe_stage_reg #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter logic [31:0] BUBBLE_VALUE = 32'h0000_0013,
   parameter int unsigned SKID_EN      = 1,
   parameter int unsigned STAT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            occupancy
`ifdef PIPE_STAT_EN
   ,
   output logic [STAT_WIDTH-1:0] stall_cnt,
   output logic [STAT_WIDTH-1:0] bubble_cnt
`endif
);

   localparam logic [DATA_WIDTH-1:0] BUBBLE = DATA_WIDTH'(BUBBLE_VALUE);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] main_q, main_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic                  in_ready_q;
   logic                  it, ot;

   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;
   // Skid mode presents a registered ready; single-entry mode must look through to out_ready.
   assign in_ready  = (SKID_EN != 0) ? in_ready_q : (!out_valid || out_ready);
   assign it        = in_valid && in_ready;
   assign ot        = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = BUBBLE;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (it) begin
                  main_d  = in_data;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (ot && it) begin
                  main_d = in_data;
               end else if (ot) begin
                  main_d  = BUBBLE;
                  state_d = ST_EMPTY;
               end else if (it && (SKID_EN != 0)) begin
                  skid_d  = in_data;
                  state_d = ST_TWO;
               end
            end
            ST_TWO: begin
               if (ot) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: begin
               main_d  = BUBBLE;
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         main_q     <= BUBBLE;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         in_ready_q <= (state_d != ST_TWO);
      end
   end

   // The skid slot is only meaningful while the state says TWO, so it carries no reset.
   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

`ifdef PIPE_STAT_EN
   function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [STAT_WIDTH-1:0] stall_q, bubble_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (out_valid && !out_ready) stall_q <= sat_inc(stall_q);
         if (!out_valid && out_ready) bubble_q <= sat_inc(bubble_q);
      end
   end

   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;
`endif

endmodule
